fc_bias_relu_stage: RTL and testbench
=====================================

// Module: fc_bias_relu_stage
// PURPOSE
//  Downstream neighbour of the 1x784 x 784x64 PE array: consumes its 64-lane psum vector on the
//  array's finish pulse, adds a per-neuron bias with saturation, applies optional ReLU, and
//  presents the 64-element activation vector to the next FC layer through a valid/ready handshake.
//  Processes LANES elements per cycle, trading latency for area.
// PARAMETERS
//  N      64  vector length; number of neurons from the PE array
//  W      16  element width; signed fixed point, same Q format as psum and bias
//  LANES  4   elements processed per cycle; must divide N
// PORTS
//  clk         in   1    clock
//  rst         in   1    asynchronous, active-low reset
//  en          in   1    global enable; low freezes the FSM, counter and registers
//  psum_in     in   N*W  psum vector from the PE array; element i = [i*W +: W]
//  psum_valid  in   1    PE array finish pulse; psum_in is valid in the same cycle
//  bias        in   N*W  per-neuron bias, same packing; sampled with psum_in
//  relu_en     in   1    1 = clamp negative results to 0; sampled at capture
//  act_out     out  N*W  activation vector; stable while act_valid=1
//  act_valid   out  1    result available
//  act_ready   in   1    downstream accepts; transfer occurs when act_valid & act_ready
//  busy        out  1    high in PROC and DONE
//  sat_cnt     out  7    number of elements saturated in the current vector ($clog2(N+1))
//  drop_err    out  1    sticky; psum_valid arrived while not IDLE; cleared only by reset
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, idx=0, all registers and outputs =0.
//  FSM IDLE -> PROC -> DONE -> IDLE. No transitions and no register updates while en=0.
//  IDLE: when en & psum_valid: capture psum_in, bias, relu_en; clear sat_cnt; idx=0; go to PROC.
//  PROC: per cycle, for k in 0..LANES-1, e = idx+k:
//   sum = sext(psum[e]) + sext(bias[e]) at W+1 bits; saturate to [-2^(W-1), 2^(W-1)-1].
//   Each clamped element increments sat_cnt. If relu_en and the result is <0, output 0.
//   A saturated negative with ReLU counts as saturated and outputs 0.
//   Write the result to act_reg[e]; idx += LANES.
//   The beat with idx = N-LANES goes to DONE.
//  Latency: act_valid rises N/LANES edges after the capture edge (16 at defaults).
//  DONE: act_valid=1; act_out and sat_cnt held. On act_valid & act_ready (en=1): go to IDLE.
//   act_valid falls next cycle. act_ready is ignored outside DONE.
//  psum_valid in PROC or DONE is ignored (no recapture) and sets drop_err.
//  In IDLE, act_out keeps the last result; act_valid=0.
//  No same-cycle DONE->capture: a psum_valid in the accept cycle is dropped and flags drop_err.
//  Reset mid-PROC or mid-DONE: immediate abort; all state zeroed; partial vector discarded.
//  Width rules: add is sign-extended by 1 bit, never wraps; no rescale, since bias and psum share
//  the Q format.
// STRUCTURE
//  Shared include fc_defs.vh: N, W, LANES defaults; state encodings
//   S_IDLE=2'd0, S_PROC=2'd1, S_DONE=2'd2; SAT_MAX=16'h7FFF, SAT_MIN=16'h8000.
//  Sub-module sat_add_relu (combinational, one per lane, LANES instances):
//   in a, b [W], relu_en; out y [W], sat [1].
//  Top level: FSM, idx counter, capture registers, act_reg, sat_cnt adder tree over LANES flags.
// TESTING
//  1. psum all 16'h0200, bias 0, relu_en=1: act_valid 16 cycles after capture; all 16'h0200;
//     sat_cnt=0.
//  2. psum all 16'h7F00, bias all 16'h0200: all 16'h7FFF, sat_cnt=64.
//     psum 16'h8100 + bias 16'hFE00 gives 16'h8000 with relu_en=0.
//  3. psum all 16'hFE00, bias 0: relu_en=1 gives all 0; relu_en=0 gives all 16'hFE00; sat_cnt=0.
//  4. Backpressure: act_ready low 5 cycles in DONE: act_valid and act_out hold;
//     psum_valid pulsed then sets drop_err=1, no recapture; ready high gives IDLE next cycle.
//  5. en low for 3 cycles at beat 7: idx and act_reg frozen; act_valid arrives 19 cycles after
//     capture; data identical to case 1.
//  6. rst low at beat 7: all outputs 0 asynchronously; IDLE.
//     Next vector (psum 16'h0100, bias 16'h0100) gives all 16'h0200.

Source files
------------

// File: rtl/fc_bias_relu_stage_pkg.sv
// Shared definitions for the FC bias + ReLU stage: default geometry, FSM states, saturation limits.
package fc_bias_relu_stage_pkg;

    localparam int unsigned FC_N     = 64;
    localparam int unsigned FC_W     = 16;
    localparam int unsigned FC_LANES = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PROC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/fc_bias_relu_stage_sat_add_relu.sv
// One lane: signed saturating add of psum and bias, followed by optional ReLU clamp.
module sat_add_relu #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         relu_en,
    output logic [W-1:0] y,
    output logic         sat
);

    logic [W:0] sum;

    always_comb begin
        sum = {a[W-1], a} + {b[W-1], b};
        sat = 1'b0;
        y   = sum[W-1:0];
        // Overflow shows up as the extra sign bit disagreeing with the result's sign bit.
        if (sum[W] != sum[W-1]) begin
            sat = 1'b1;
            y   = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        if (relu_en && y[W-1]) begin
            y = '0;
        end
    end

endmodule

// File: rtl/fc_bias_relu_stage.sv
// Captures the PE-array psum vector, adds bias with saturation and optional ReLU LANES
// elements per cycle, then offers the activation vector downstream via valid/ready.
module fc_bias_relu_stage
    import fc_bias_relu_stage_pkg::*;
#(
    parameter int unsigned N     = FC_N,
    parameter int unsigned W     = FC_W,
    parameter int unsigned LANES = FC_LANES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N*W-1:0]           psum_in,
    input  logic                     psum_valid,
    input  logic [N*W-1:0]           bias,
    input  logic                     relu_en,
    output logic [N*W-1:0]           act_out,
    output logic                     act_valid,
    input  logic                     act_ready,
    output logic                     busy,
    output logic [$clog2(N+1)-1:0]   sat_cnt,
    output logic                     drop_err
);

    localparam int unsigned IDXW = $clog2(N);
    localparam int unsigned CW   = $clog2(N+1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - LANES);

    state_t          state;
    logic [IDXW-1:0] idx;
    logic [W-1:0]    psum_q [N];
    logic [W-1:0]    bias_q [N];
    logic [W-1:0]    act_q  [N];
    logic            relu_q;

    logic [W-1:0]     lane_y [LANES];
    logic [LANES-1:0] lane_sat;
    logic [CW-1:0]    beat_sat;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sat_add_relu #(.W(W)) u_lane (
            .a       (psum_q[idx + IDXW'(k)]),
            .b       (bias_q[idx + IDXW'(k)]),
            .relu_en (relu_q),
            .y       (lane_y[k]),
            .sat     (lane_sat[k])
        );
    end

    always_comb begin
        beat_sat = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            beat_sat = beat_sat + CW'(lane_sat[k]);
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign act_out[i*W +: W] = act_q[i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            relu_q    <= 1'b0;
            act_valid <= 1'b0;
            busy      <= 1'b0;
            sat_cnt   <= '0;
            drop_err  <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                psum_q[i] <= '0;
                bias_q[i] <= '0;
                act_q[i]  <= '0;
            end
        end else if (en) begin
            case (state)
                S_IDLE: begin
                    if (psum_valid) begin
                        for (int unsigned i = 0; i < N; i++) begin
                            psum_q[i] <= psum_in[i*W +: W];
                            bias_q[i] <= bias[i*W +: W];
                        end
                        relu_q  <= relu_en;
                        sat_cnt <= '0;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= S_PROC;
                    end
                end
                S_PROC: begin
                    if (psum_valid) drop_err <= 1'b1;
                    for (int unsigned k = 0; k < LANES; k++) begin
                        act_q[idx + IDXW'(k)] <= lane_y[k];
                    end
                    sat_cnt <= sat_cnt + beat_sat;
                    idx     <= idx + IDXW'(LANES);
                    if (idx == LAST_IDX) begin
                        act_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // A psum_valid coinciding with the accept is still dropped.
                    if (psum_valid) drop_err <= 1'b1;
                    if (act_ready) begin
                        act_valid <= 1'b0;
                        busy      <= 1'b0;
                        idx       <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_bias_relu_stage.sv
// Directed bench for fc_bias_relu_stage with hand-computed expected vectors.
module tb_fc_bias_relu_stage;

    localparam int unsigned N     = 64;
    localparam int unsigned W     = 16;
    localparam int unsigned LANES = 4;
    localparam int unsigned CW    = 7;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [N*W-1:0] psum_in;
    logic           psum_valid;
    logic [N*W-1:0] bias;
    logic           relu_en;
    logic [N*W-1:0] act_out;
    logic           act_valid;
    logic           act_ready;
    logic           busy;
    logic [CW-1:0]  sat_cnt;
    logic           drop_err;

    int checks = 0;
    int errors = 0;

    fc_bias_relu_stage #(.N(N), .W(W), .LANES(LANES)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .psum_in    (psum_in),
        .psum_valid (psum_valid),
        .bias       (bias),
        .relu_en    (relu_en),
        .act_out    (act_out),
        .act_valid  (act_valid),
        .act_ready  (act_ready),
        .busy       (busy),
        .sat_cnt    (sat_cnt),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [N*W-1:0] exp);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s[%0d]", tag, i), 32'(act_out[i*W +: W]), 32'(exp[i*W +: W]));
        end
    endtask

    function automatic logic [N*W-1:0] fill(input logic [W-1:0] v);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [N*W-1:0] p, input logic [N*W-1:0] b, input logic r);
        psum_in    = p;
        bias       = b;
        relu_en    = r;
        psum_valid = 1'b1;
        tick();
        psum_valid = 1'b0;
    endtask

    // Counts edges after capture until act_valid; 200 means it never came.
    task automatic wait_valid(input int start, output int cyc);
        cyc = start;
        while (!act_valid && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic accept(input string tag);
        act_ready = 1'b1;
        tick();
        act_ready = 1'b0;
        check({tag, ".valid_fall"}, 32'(act_valid), 32'd0);
        check({tag, ".busy_fall"},  32'(busy),      32'd0);
    endtask

    task automatic run(input string tag, input logic [N*W-1:0] p, input logic [N*W-1:0] b,
                       input logic r, input logic [N*W-1:0] exp, input int exp_sat);
        int cyc;
        capture(p, b, r);
        check({tag, ".busy"}, 32'(busy), 32'd1);
        wait_valid(0, cyc);
        check({tag, ".latency"}, 32'(cyc), 32'd16);
        check_vec({tag, ".act"}, exp);
        check({tag, ".sat_cnt"}, 32'(sat_cnt), 32'(exp_sat));
        accept(tag);
    endtask

    logic [N*W-1:0] p_v, b_v, e_v, held;
    int cyc;

    initial begin
        rst = 1'b0; en = 1'b1; psum_in = '0; psum_valid = 1'b0; bias = '0;
        relu_en = 1'b0; act_ready = 1'b0;
        tick(); tick();
        check_vec("reset.act", '0);
        check("reset.valid", 32'(act_valid), 32'd0);
        check("reset.busy",  32'(busy),      32'd0);
        check("reset.sat",   32'(sat_cnt),   32'd0);
        check("reset.drop",  32'(drop_err),  32'd0);
        rst = 1'b1;
        tick();

        // 1: plain pass-through with ReLU on positive data
        run("t1", fill(16'h0200), fill(16'h0000), 1'b1, fill(16'h0200), 0);
        check("t1.idle_hold", 32'(act_out[0 +: W]), 32'h0200);

        // 2: positive and negative saturation
        run("t2pos", fill(16'h7F00), fill(16'h0200), 1'b0, fill(16'h7FFF), 64);
        run("t2neg", fill(16'h8100), fill(16'hFE00), 1'b0, fill(16'h8000), 64);
        run("t2negrelu", fill(16'h8100), fill(16'hFE00), 1'b1, fill(16'h0000), 64);

        // mixed: even lanes saturate, odd lanes 0x0100+0x0100
        for (int i = 0; i < N; i++) begin
            p_v[i*W +: W] = (i % 2 == 0) ? 16'h7F00 : 16'h0100;
            b_v[i*W +: W] = (i % 2 == 0) ? 16'h0200 : 16'h0100;
            e_v[i*W +: W] = (i % 2 == 0) ? 16'h7FFF : 16'h0200;
        end
        run("tmix", p_v, b_v, 1'b0, e_v, 32);

        // per-element placement: psum = 16*i, bias = i, result = 17*i
        for (int i = 0; i < N; i++) begin
            p_v[i*W +: W] = 16'(i * 16);
            b_v[i*W +: W] = 16'(i);
            e_v[i*W +: W] = 16'(i * 17);
        end
        run("tidx", p_v, b_v, 1'b0, e_v, 0);

        // 3: negative results with and without ReLU
        run("t3relu", fill(16'hFE00), fill(16'h0000), 1'b1, fill(16'h0000), 0);
        run("t3lin",  fill(16'hFE00), fill(16'h0000), 1'b0, fill(16'hFE00), 0);

        // 4: backpressure in DONE, dropped psum_valid
        capture(fill(16'h0200), fill(16'h0000), 1'b1);
        wait_valid(0, cyc);
        check("t4.latency", 32'(cyc), 32'd16);
        check("t4.drop_pre", 32'(drop_err), 32'd0);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                psum_in = fill(16'h1234); bias = fill(16'h0001); psum_valid = 1'b1;
            end
            tick();
            psum_valid = 1'b0;
            check($sformatf("t4.hold_valid%0d", c), 32'(act_valid), 32'd1);
            check($sformatf("t4.hold_act%0d", c), 32'(act_out[5*W +: W]), 32'h0200);
        end
        check("t4.drop", 32'(drop_err), 32'd1);
        check_vec("t4.act", fill(16'h0200));
        // accept with a simultaneous psum_valid: must not be captured
        psum_valid = 1'b1;
        accept("t4");
        psum_valid = 1'b0;
        tick();
        check("t4.no_recapture", 32'(busy), 32'd0);
        check("t4.drop_sticky", 32'(drop_err), 32'd1);

        // 5: enable held low for 3 cycles after 7 beats
        capture(fill(16'h0200), fill(16'h0000), 1'b1);
        repeat (7) tick();
        en = 1'b0;
        repeat (3) tick();
        check("t5.frozen_valid", 32'(act_valid), 32'd0);
        check("t5.frozen_busy", 32'(busy), 32'd1);
        en = 1'b1;
        wait_valid(10, cyc);
        check("t5.latency", 32'(cyc), 32'd19);
        check_vec("t5.act", fill(16'h0200));
        check("t5.sat_cnt", 32'(sat_cnt), 32'd0);
        accept("t5");

        // 6: asynchronous reset mid-vector
        capture(fill(16'h7F00), fill(16'h0200), 1'b0);
        repeat (7) tick();
        #3 rst = 1'b0;
        #1;
        check_vec("t6.act", '0);
        check("t6.valid", 32'(act_valid), 32'd0);
        check("t6.busy",  32'(busy),      32'd0);
        check("t6.sat",   32'(sat_cnt),   32'd0);
        check("t6.drop",  32'(drop_err),  32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("t6.idle", 32'(busy), 32'd0);
        run("t6next", fill(16'h0100), fill(16'h0100), 1'b0, fill(16'h0200), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
